// File: rtl/sc_leak_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_leak_monitor_if
// Brief    : Bundle between the paired RSA copies and the leak monitor.
// Revision : 1.0  initial release
// ============================================================================
interface sc_leak_monitor_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic                 start;
   logic                 finish_1;
   logic                 finish_2;
   logic [2*WIDTH-1:0]   m_decrypted_1;
   logic [2*WIDTH-1:0]   m_decrypted_2;
   logic                 busy;
   logic                 done;
   logic                 leak;
   logic                 mismatch;
   logic                 timeout;
   logic [CNT_W-1:0]     cycles_1;
   logic [CNT_W-1:0]     cycles_2;
   logic [CNT_W-1:0]     skew;
   logic                 leak_sticky;

   modport master (
      output start, finish_1, finish_2, m_decrypted_1, m_decrypted_2,
      input  busy, done, leak, mismatch, timeout, cycles_1, cycles_2, skew, leak_sticky
   );

   modport slave (
      input  start, finish_1, finish_2, m_decrypted_1, m_decrypted_2,
      output busy, done, leak, mismatch, timeout, cycles_1, cycles_2, skew, leak_sticky
   );
endinterface
`default_nettype wire

// File: rtl/sc_leak_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sc_leak_monitor
// Brief    : Measures latency of two self-composed RSA copies from a shared
//            start and flags timing (leak) or result (mismatch) divergence.
//            Optional macro SC_LEAK_STICKY_EN builds the sticky leak flag.
// Revision : 1.0  initial release
// ============================================================================
module sc_leak_monitor #(
   parameter int          WIDTH   = 8,
   parameter int          CNT_W   = 16,
   parameter int unsigned TIMEOUT = 32'hFFFF
) (
   input  wire logic           clk,
   input  wire logic           rst,
   sc_leak_monitor_if.slave    bus
);

   localparam logic [1:0]       S_IDLE  = 2'd0;
   localparam logic [1:0]       S_RUN   = 2'd1;
   localparam logic [1:0]       S_DONE  = 2'd2;
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 got1_q, got2_q;
   logic [2*WIDTH-1:0]   data1_q, data2_q;
   logic [CNT_W-1:0]     cyc1_q, cyc2_q;
   logic                 leak_q, mism_q, tmo_q;
   logic [CNT_W-1:0]     skew_q;

   logic                 start_acc;
   logic                 cap1, cap2;
   logic                 got1_d, got2_d;
   logic [CNT_W-1:0]     cyc1_d, cyc2_d;
   logic [2*WIDTH-1:0]   data1_d, data2_d;
   logic                 both_d, tmo_d;
   logic                 leak_d, mism_d;
   logic [CNT_W-1:0]     skew_d;

   // Capture view including this edge's captures, so the verdict sees them.
   assign start_acc = bus.start && (state_q != S_RUN);
   assign cap1      = (state_q == S_RUN) && bus.finish_1 && !got1_q;
   assign cap2      = (state_q == S_RUN) && bus.finish_2 && !got2_q;
   assign got1_d    = got1_q | cap1;
   assign got2_d    = got2_q | cap2;
   assign cyc1_d    = cap1 ? cnt_q : cyc1_q;
   assign cyc2_d    = cap2 ? cnt_q : cyc2_q;
   assign data1_d   = cap1 ? bus.m_decrypted_1 : data1_q;
   assign data2_d   = cap2 ? bus.m_decrypted_2 : data2_q;
   assign both_d    = got1_d & got2_d;
   assign tmo_d     = !both_d && (cnt_q == TMO_CNT);
   assign leak_d    = both_d ? (cyc1_d != cyc2_d) : (got1_d ^ got2_d);
   assign mism_d    = both_d && (data1_d != data2_d);
   assign skew_d    = (cyc1_d > cyc2_d) ? (cyc1_d - cyc2_d) : (cyc2_d - cyc1_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (both_d || tmo_d) state_d = S_DONE;
         S_DONE:  if (bus.start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == S_RUN);
      bus.done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         got1_q  <= 1'b0;
         got2_q  <= 1'b0;
         data1_q <= '0;
         data2_q <= '0;
         cyc1_q  <= '0;
         cyc2_q  <= '0;
         leak_q  <= 1'b0;
         mism_q  <= 1'b0;
         tmo_q   <= 1'b0;
         skew_q  <= '0;
      end else if (start_acc) begin
         cnt_q   <= '0;
         got1_q  <= 1'b0;
         got2_q  <= 1'b0;
         data1_q <= '0;
         data2_q <= '0;
         cyc1_q  <= '0;
         cyc2_q  <= '0;
         leak_q  <= 1'b0;
         mism_q  <= 1'b0;
         tmo_q   <= 1'b0;
         skew_q  <= '0;
      end else if (state_q == S_RUN) begin
         cnt_q   <= (cnt_q == TMO_CNT) ? cnt_q : cnt_q + 1'b1;
         got1_q  <= got1_d;
         got2_q  <= got2_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         cyc1_q  <= cyc1_d;
         cyc2_q  <= cyc2_d;
         if (both_d) begin
            leak_q <= leak_d;
            mism_q <= mism_d;
            skew_q <= skew_d;
         end else if (tmo_d) begin
            tmo_q  <= 1'b1;
            leak_q <= leak_d;
            mism_q <= 1'b0;
            skew_q <= '0;
         end
      end
   end

   assign bus.leak     = leak_q;
   assign bus.mismatch = mism_q;
   assign bus.timeout  = tmo_q;
   assign bus.cycles_1 = cyc1_q;
   assign bus.cycles_2 = cyc2_q;
   assign bus.skew     = skew_q;

`ifdef SC_LEAK_STICKY_EN
   logic sticky_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if ((state_q == S_RUN) && (both_d || tmo_d) && (leak_d || mism_d)) begin
         sticky_q <= 1'b1;
      end
   end

   assign bus.leak_sticky = sticky_q;
`else
   assign bus.leak_sticky = 1'b0;
`endif

endmodule
`default_nettype wire
